// File: rtl/dff_ctrl_pkg.sv
// Purpose: shared FSM state encodings and pointer/owner width helper for the shared-register arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Width of the round-robin pointer and owner index. A single requester
    // still needs a 1-bit index so the vectors never collapse to zero width.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_dff_reg.sv
// Purpose: WIDTH-bit D register with load enable, exposing q and its complement.
// Latency: d captured on the rising edge where load_en=1; q visible after that edge.
// Backpressure: none; load_en is obeyed every cycle.
//
// Ports: clk, rst (async active-low), load_en, d[WIDTH] -> q[WIDTH], q_bar[WIDTH].
module shared_dff_reg
    import dff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    // Complement is derived, never stored, so it can never disagree with q.
    assign q_bar = ~q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Purpose: round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// Latency: grant 1 edge after req sampled in IDLE; write 1 edge after grant.
// Backpressure: non-owners wait with req held; the owner keeps the grant until it drops req.
//
// Ports: clk, rst (async active-low), req[N_REQ], wr_data[N_REQ*WIDTH]
//        -> gnt[N_REQ] (one-hot), owner, busy, q[WIDTH], q_bar[WIDTH].
module dff_bank_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WIDTH-1:0]    wr_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [ptr_width(N_REQ)-1:0] owner,
    output logic                      busy,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          q_bar
);

    localparam int PW = ptr_width(N_REQ);

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;

    logic          sel_vld;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;
    logic          load_en;
    logic [WIDTH-1:0] wr_dat;

    // Circular search starting at ptr. N_REQ is a power of two, so the
    // PW-bit addition wraps from N_REQ-1 to 0 without an explicit modulo.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_q + PW'(i);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign wr_dat = wr_data[owner_q*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        load_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d = ST_GRANT;
                    owner_d = sel_idx;
                end
            end
            ST_GRANT: begin
                // Pointer advances even on abort so an aborting requester
                // cannot starve the others.
                ptr_d = owner_q + PW'(1);
                if (req[owner_q]) begin
                    load_en = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Grant is decoded from state and owner so it is glitch-free relative
    // to the registers and automatically zero in IDLE.
    always_comb begin
        busy = (state_q != ST_IDLE);
        gnt  = '0;
        if (busy) begin
            gnt = N_REQ'(1) << owner_q;
        end
    end

    assign owner = owner_q;

    shared_dff_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .d       (wr_dat),
        .q       (q),
        .q_bar   (q_bar)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Purpose: self-checking bench for dff_bank_arbiter with directed steps and randomized traffic.
// Latency: outputs checked 1 time unit after each rising edge against a transaction-level model.
// Backpressure: requesters hold req until they choose to release.
module tb_dff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   q_bar;

    int vectors;
    int miscompares;

    // Reference model: who holds the register, what phase of the
    // transaction we are in, whose turn is next, and the stored value.
    localparam int PH_FREE = 0;
    localparam int PH_WRITE = 1;
    localparam int PH_OWNED = 2;
    int m_phase;
    int m_owner;
    int m_next;
    int m_val;

    dff_bank_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_data (wr_data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .q_bar   (q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_FREE;
        m_owner = 0;
        m_next  = 0;
        m_val   = 0;
    endtask

    function automatic int slice_of(input int idx);
        return int'((wr_data >> (idx * W)) & 32'hFF);
    endfunction

    // Apply the arbitration rules to the inputs present at a rising edge.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (m_phase == PH_FREE) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_next + k) % N;
                if (m_phase == PH_FREE && req[idx]) begin
                    m_owner = idx;
                    m_phase = PH_WRITE;
                end
            end
        end else if (m_phase == PH_WRITE) begin
            m_next = (m_owner + 1) % N;
            if (req[m_owner]) begin
                m_val   = slice_of(m_owner);
                m_phase = PH_OWNED;
            end else begin
                m_phase = PH_FREE;
            end
        end else begin
            if (!req[m_owner]) m_phase = PH_FREE;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_gnt;
        exp_gnt = (m_phase != PH_FREE) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, ".gnt"},   {28'd0, gnt},  exp_gnt);
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, m_phase != PH_FREE});
        chk({tag, ".owner"}, {30'd0, owner}, m_owner);
        chk({tag, ".q"},     {24'd0, q},    m_val);
        chk({tag, ".q_bar"}, {24'd0, q_bar}, (~m_val) & 32'hFF);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst     = 1'b0;
        req     = N'($urandom);
        wr_data = $urandom;

        // Reset held with random activity on the inputs.
        #2;
        check_model("rst0");
        for (int c = 0; c < 3; c++) begin
            req     = N'($urandom);
            wr_data = $urandom;
            step("rst_hold");
            chk("rst_gnt",   {28'd0, gnt},   32'h0);
            chk("rst_q_bar", {24'd0, q_bar}, 32'hFF);
        end
        req = '0;
        rst = 1'b1;

        // Single requester 2.
        wr_data = 32'h44A5_3C0F;
        req = 4'b0100;
        step("single_req");
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        step("single_wr");
        chk("single_q",     {24'd0, q},     32'hA5);
        chk("single_q_bar", {24'd0, q_bar}, 32'h5A);
        req = 4'b0000;
        step("single_rel");
        chk("single_gnt0", {28'd0, gnt}, 32'h0);

        // Wrap-around: pointer now at 3, requesters 0 and 1 pending.
        req = 4'b0011;
        step("wrap_g0");
        chk("wrap_gnt0", {28'd0, gnt}, 32'h1);
        step("wrap_w0");
        req = 4'b0010;
        step("wrap_r0");
        step("wrap_g1");
        chk("wrap_gnt1", {28'd0, gnt}, 32'h2);
        step("wrap_w1");
        chk("wrap_q1", {24'd0, q}, 32'h3C);
        req = 4'b0000;
        step("wrap_r1");

        // Reset pulsed in the middle of HOLD.
        req = 4'b1000;
        step("mid_g3");
        step("mid_w3");
        chk("mid_q3", {24'd0, q}, 32'h44);
        rst = 1'b0;
        model_reset();
        #1;
        check_model("mid_rst");
        chk("mid_rst_q", {24'd0, q}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        req = 4'b0000;
        step("mid_rst_hold");
        rst = 1'b1;

        // Fairness: everyone requesting, each releases one cycle after its write.
        wr_data = 32'h4433_2211;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int i;
            i = k % N;
            step("fair_g");
            chk("fair_gnt", {28'd0, gnt}, 32'd1 << i);
            step("fair_w");
            chk("fair_q", {24'd0, q}, slice_of(i));
            req[i] = 1'b0;
            step("fair_r");
            chk("fair_idle", {31'd0, busy}, 32'h0);
            if (k < 4) req[i] = 1'b1;
            else req = '0;
        end

        // Abort: requester 1 drops during GRANT; pointer moves on to 2.
        req = 4'b0010;
        step("abort_g1");
        req = 4'b0000;
        step("abort_drop");
        chk("abort_q", {24'd0, q}, 32'h11);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        req = 4'b1001;
        step("abort_next");
        chk("abort_gnt", {28'd0, gnt}, 32'h8);
        step("abort_w");
        req = 4'b0000;
        step("abort_rel");

        // Hold stability while another requester waits.
        req = 4'b0001;
        step("hold_g0");
        step("hold_w0");
        req = 4'b1001;
        for (int c = 0; c < 10; c++) begin
            step("hold_keep");
            chk("hold_gnt", {28'd0, gnt}, 32'h1);
            chk("hold_q",   {24'd0, q},   32'h11);
        end
        req = 4'b1000;
        step("hold_rel");
        chk("hold_idle", {28'd0, gnt}, 32'h0);
        step("hold_g3");
        chk("hold_gnt3", {28'd0, gnt}, 32'h8);
        step("hold_w3");
        req = 4'b0000;
        step("hold_r3");

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) wr_data[i*W +: W] = W'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_model("rnd_arst");
                rst = 1'b1;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
